seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial sequence detector; successor to the fixed 4-state Mealy FSM blocks in the labs.
- Matches a runtime-loadable PAT_W-bit pattern on a 1-bit qualified input stream.
- Provides a combinational Mealy match, a registered Moore-style match, selectable overlap/non-overlap detection, and a saturating match counter.
- Sits between an input synchroniser/debouncer and LED/7-seg display logic.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16).
- CNT_W, 8, match counter width.
- PAT_RST, 4'b1011, pattern register value after reset (PAT_W bits, MSB is the first bit received).

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- In  in  1  serial data bit.
- in_valid  in  1  In is sampled only when high.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern, MSB first.
- overlap  in  1  1 = overlapping detection; 0 = restart after a match.
- out  out  1  Mealy match, combinational, same cycle as the final bit.
- out_q  out  1  registered match, one cycle after out.
- match_cnt  out  CNT_W  saturating count of matches.
- State  out  clog2(PAT_W)  fill level: valid history bits held, 0..PAT_W-1.

Behaviour:
- Reset (sync, sampled on clk rise) forces the following, and has priority over everything:
  - pattern register = PAT_RST
  - history = 0
  - State = 0
  - out_q = 0
  - match_cnt = 0
  - out is 0 in the cycle Reset is high.
- Internal storage:
  - history register hist holds PAT_W-1 bits; the newest bit is in the LSB.
  - State holds the fill level.
- Match condition, combinational: match = in_valid & ~pat_load & ~Reset & (State == PAT_W-1) & ({hist, In} == pattern).
- out = match, with zero latency.
- When pat_load is high:
  - pattern <= pat_in
  - hist <= 0, State <= 0
  - the In bit is discarded even if in_valid is high
  - out = 0 in that cycle
  - match_cnt is unchanged.
- When in_valid is high and pat_load is low, on each clk:
  - If match & ~overlap: hist <= 0 and State <= 0 (non-overlap restart).
  - Otherwise: hist <= {hist[PAT_W-3:0], In}, and State <= min(State+1, PAT_W-1), saturating.
- When in_valid is low: all state holds, out = 0, and out_q follows on the next clock (becomes 0).
- out_q <= match on every clock.
- match_cnt <= match_cnt + 1 on each match.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by Reset.
- overlap may change at any time; it takes effect from the current cycle's match decision.
- pat_load takes effect on the same edge it is sampled.
  - The first bit after a load counts as bit 1 of a new window.
  - The earliest match is PAT_W valid bits after the load.
- Reset mid-sequence discards any partial history; no match may complete using bits from before the reset.
- No illegal states are possible: State is always kept at or below PAT_W-1.

Decomposition:
- Shared package seq_pkg holds:
  - default PAT_W / CNT_W / PAT_RST constants
  - a clog2 function.
- One sub-module, sat_counter (parameter W; ports clk, Reset, inc, q), used for match_cnt.
- History, fill and match logic stay in the top level.

Test Plan:
1. Reset, pattern 1011, overlap=1, in_valid=1, stream 1,0,1,1,0,1,1:
   - out=1 on bits 4 and 7 only
   - out_q=1 one cycle after each
   - match_cnt=2.
2. Same stream with overlap=0:
   - out=1 on bit 4 only
   - State=0 after bit 4, then State=3 after bit 7
   - match_cnt=1.
3. pat_load=1 with pat_in=4'b1111 and in_valid=1, In=1 in the same cycle:
   - out=0, State=0
   - then stream 1,1,1,1 gives out=1 on the 4th bit, and further 1s keep out=1 each cycle (overlap=1).
4. Stall test: stream 1,0 then in_valid=0 for 3 cycles with In toggling, then 1,1:
   - out=1 on the final bit
   - State holds at 2 during the stall
   - out=0 while stalled.
5. Reset asserted after 1,0,1, then stream 1:
   - no match
   - State=1 after that bit.
6. CNT_W=2, pattern 11, overlap=1, six consecutive 1s:
   - out high on bits 2..6 (5 matches)
   - match_cnt saturates at 3 and stays there.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared defaults, update-action encoding and a constant clog2 helper
// for the parametrised sequence detector.
package seq_pkg;

  localparam int              DEF_PAT_W   = 4;
  localparam int              DEF_CNT_W   = 8;
  localparam logic [3:0]      DEF_PAT_RST = 4'b1011;

  // What happens to the history/fill registers on the next clock edge.
  typedef enum logic [1:0] {
    UPD_HOLD,     // no valid bit this cycle
    UPD_LOAD,     // new pattern loaded, window cleared
    UPD_RESTART,  // non-overlap match, window cleared
    UPD_SHIFT     // append the new bit to the history
  } upd_e;

  // Bits needed to index n values; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: step by one unless already at all-ones.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) q_d = q_q + 1'b1;
  end

  // Count register; Reset is the only way back to zero.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (Reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial sequence detector with runtime-loadable pattern, Mealy and
// registered match outputs, overlap control and a saturating match count.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST)
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      In,
  input  logic                      in_valid,
  input  logic                      pat_load,
  input  logic [PAT_W-1:0]          pat_in,
  input  logic                      overlap,
  output logic                      out,
  output logic                      out_q,
  output logic [CNT_W-1:0]          match_cnt,
  output logic [clog2(PAT_W)-1:0]   State
);

  localparam int              ST_W    = clog2(PAT_W);
  localparam logic [ST_W-1:0] ST_FULL = ST_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [ST_W-1:0]  fill_q, fill_d;
  logic             match_q;
  logic             match;
  logic [PAT_W-1:0] window;
  upd_e             upd;

  // Candidate window and Mealy match: full history plus the bit arriving now.
  always_comb begin
    window = {hist_q, In};
    match  = in_valid & ~pat_load & ~Reset & (fill_q == ST_FULL) & (window == pat_q);
  end

  // Pick the update action; a load always wins over the data stream.
  always_comb begin
    upd = UPD_HOLD;
    if (pat_load)                upd = UPD_LOAD;
    else if (in_valid && match && !overlap) upd = UPD_RESTART;
    else if (in_valid)           upd = UPD_SHIFT;
  end

  // Next pattern, history and fill level; fill saturates at PAT_W-1.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    case (upd)
      UPD_LOAD: begin
        pat_d  = pat_in;
        hist_d = '0;
        fill_d = '0;
      end
      UPD_RESTART: begin
        hist_d = '0;
        fill_d = '0;
      end
      UPD_SHIFT: begin
        hist_d = window[PAT_W-2:0];
        fill_d = (fill_q == ST_FULL) ? ST_FULL : fill_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Pattern, history, fill and registered match; Reset takes priority.
  always_ff @(posedge clk) begin
    if (Reset) begin
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .Reset (Reset),
    .inc   (match),
    .q     (match_cnt)
  );

  assign out   = match;
  assign out_q = match_q;
  assign State = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: scoreboard of expected
// registered results plus explicit scenario checks.
module tb_seq_detect_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default 4-bit pattern, 8-bit counter
  logic       a_rst = 1'b0, a_in = 1'b0, a_valid = 1'b0, a_load = 1'b0, a_ovl = 1'b1;
  logic [3:0] a_pat = 4'h0;
  logic       a_out, a_out_q;
  logic [7:0] a_cnt;
  logic [1:0] a_state;

  // Instance B: 2-bit pattern 11, 2-bit counter for saturation
  logic       b_rst = 1'b0, b_in = 1'b0, b_valid = 1'b0, b_load = 1'b0, b_ovl = 1'b1;
  logic [1:0] b_pat = 2'b00;
  logic       b_out, b_out_q;
  logic [1:0] b_cnt;
  logic [0:0] b_state;

  seq_detect_param #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1011)) dut_a (
    .clk(clk), .Reset(a_rst), .In(a_in), .in_valid(a_valid), .pat_load(a_load),
    .pat_in(a_pat), .overlap(a_ovl), .out(a_out), .out_q(a_out_q),
    .match_cnt(a_cnt), .State(a_state)
  );

  seq_detect_param #(.PAT_W(2), .CNT_W(2), .PAT_RST(2'b11)) dut_b (
    .clk(clk), .Reset(b_rst), .In(b_in), .in_valid(b_valid), .pat_load(b_load),
    .pat_in(b_pat), .overlap(b_ovl), .out(b_out), .out_q(b_out_q),
    .match_cnt(b_cnt), .State(b_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int step_no  = 0;

  // Reference model: pattern, bits received since the window was last cleared, count
  logic [3:0] m_pat = 4'b1011;
  bit         m_hist[$];
  int         m_cnt = 0;

  typedef struct packed {
    logic       out_q;
    logic [1:0] state;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  logic       last_out;
  logic [1:0] last_state;

  // One clock of stimulus on instance A, with model prediction and scoreboard compare
  task automatic drive(input logic r, input logic v, input logic b, input logic l,
                       input logic [3:0] p, input logic o);
    logic       exp_out;
    logic [3:0] w;
    int         sz;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    a_rst = r; a_valid = v; a_in = b; a_load = l; a_pat = p; a_ovl = o;
    step_no++;

    exp_out = 1'b0;
    if (!r && v && !l && m_hist.size() == 3) begin
      w = {m_hist[0], m_hist[1], m_hist[2], b};
      exp_out = (w == m_pat);
    end
    if (r) begin
      m_pat = 4'b1011;
      m_hist.delete();
      m_cnt = 0;
    end else if (l) begin
      m_pat = p;
      m_hist.delete();
    end else if (v) begin
      if (exp_out && !o) m_hist.delete();
      else begin
        m_hist.push_back(b);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
      end
    end
    if (exp_out && m_cnt < 255) m_cnt++;
    sz = m_hist.size();
    e.out_q = exp_out;
    e.state = 2'((sz > 3) ? 3 : sz);
    e.cnt   = 8'(m_cnt);
    sb_q.push_back(e);

    #1;
    n_checks++;
    if (a_out !== exp_out) begin
      n_errors++;
      $display("FAIL out step %0d: got %b want %b", step_no, a_out, exp_out);
    end
    last_out = a_out;

    @(posedge clk);
    #1;
    got = {a_out_q, a_state, a_cnt};
    e   = sb_q.pop_front();
    n_checks++;
    if (got.out_q !== e.out_q) begin
      n_errors++;
      $display("FAIL out_q step %0d: got %b want %b", step_no, got.out_q, e.out_q);
    end
    n_checks++;
    if (got.state !== e.state) begin
      n_errors++;
      $display("FAIL State step %0d: got %0d want %0d", step_no, got.state, e.state);
    end
    n_checks++;
    if (got.cnt !== e.cnt) begin
      n_errors++;
      $display("FAIL match_cnt step %0d: got %0d want %0d", step_no, got.cnt, e.cnt);
    end
    last_state = a_state;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    n_checks++;
    if ({a_out_q, a_state, a_cnt} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_state: got out_q=%b State=%0d cnt=%0d want all 0", a_out_q, a_state, a_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] stream = 7'b1011011;
    logic [6:0] obs;
    test_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, stream[6-i], 1'b0, 4'h0, 1'b1);
      obs[6-i] = last_out;
    end
    n_checks++;
    if (obs !== 7'b0001001) begin
      n_errors++;
      $display("FAIL overlap_outs: got %b want 0001001", obs);
    end
    n_checks++;
    if (a_cnt !== 8'd2) begin
      n_errors++;
      $display("FAIL overlap_cnt: got %0d want 2", a_cnt);
    end
  endtask

  task automatic test_non_overlap();
    logic [6:0] stream = 7'b1011011;
    logic [6:0] obs;
    logic [1:0] st4;
    test_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, stream[6-i], 1'b0, 4'h0, 1'b0);
      obs[6-i] = last_out;
      if (i == 3) st4 = last_state;
    end
    n_checks++;
    if (obs !== 7'b0001000) begin
      n_errors++;
      $display("FAIL nonovl_outs: got %b want 0001000", obs);
    end
    n_checks++;
    if (st4 !== 2'd0 || last_state !== 2'd3) begin
      n_errors++;
      $display("FAIL nonovl_state: got %0d/%0d want 0/3", st4, last_state);
    end
    n_checks++;
    if (a_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL nonovl_cnt: got %0d want 1", a_cnt);
    end
  endtask

  task automatic test_pat_load();
    logic [5:0] obs;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
    n_checks++;
    if (last_out !== 1'b0 || a_state !== 2'd0 || a_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL load_cycle: got out=%b State=%0d cnt=%0d want 0/0/1", last_out, a_state, a_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
      obs[5-i] = last_out;
    end
    n_checks++;
    if (obs !== 6'b000111) begin
      n_errors++;
      $display("FAIL load_outs: got %b want 000111", obs);
    end
  endtask

  task automatic test_stall();
    logic [6:0] obs;
    test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1); obs[6] = last_out;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1); obs[5] = last_out;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, i[0], 1'b0, 4'h0, 1'b1);
      obs[4-i] = last_out;
      n_checks++;
      if (last_state !== 2'd2) begin
        n_errors++;
        $display("FAIL stall_state cycle %0d: got %0d want 2", i, last_state);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1); obs[1] = last_out;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1); obs[0] = last_out;
    n_checks++;
    if (obs !== 7'b0000001) begin
      n_errors++;
      $display("FAIL stall_outs: got %b want 0000001", obs);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    n_checks++;
    if (last_out !== 1'b0 || last_state !== 2'd1) begin
      n_errors++;
      $display("FAIL reset_mid: got out=%b State=%0d want 0/1", last_out, last_state);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    b_rst = 1'b1; b_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (b_cnt !== 2'd0 || b_state !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_reset: got cnt=%0d State=%0d want 0/0", b_cnt, b_state);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      b_rst = 1'b0; b_valid = 1'b1; b_in = 1'b1; b_ovl = 1'b1;
      #1;
      n_checks++;
      if (b_out !== (k >= 2)) begin
        n_errors++;
        $display("FAIL sat_out bit %0d: got %b want %b", k, b_out, (k >= 2));
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (b_cnt !== 2'((k - 1 > 3) ? 3 : k - 1)) begin
        n_errors++;
        $display("FAIL sat_cnt bit %0d: got %0d want %0d", k, b_cnt, (k - 1 > 3) ? 3 : k - 1);
      end
    end
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_pat_load();
    test_stall();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
